// File: rtl/main_memory_burst_pkg.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_pkg
// Purpose  : Shared types and sizing helpers for the burst main-memory model.
//            Holds the controller state encoding and the functions that size
//            the beat counter and the access-latency counter.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package main_memory_pkg;

    typedef enum logic [2:0] {
        MEM_IDLE     = 3'd0,
        MEM_RD_WAIT  = 3'd1,
        MEM_RD_BURST = 3'd2,
        MEM_WR_BURST = 3'd3,
        MEM_WR_WAIT  = 3'd4
    } mem_state_e;

    // Index width that never collapses to zero bits, so single-entry
    // counters still get a legal 1-bit vector.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Number of bus beats that make up one cache block.
    function automatic int mem_beats(input int block_width, input int dma_width);
        return block_width / dma_width;
    endfunction

    // Width of a counter that has to reach latency-1.
    function automatic int lat_cnt_width(input int latency);
        return clog2_min1(latency);
    endfunction

endpackage
`default_nettype wire

// File: rtl/main_memory_burst_if.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_burst_if
// Purpose  : Cache/DMA bus between a requester (master) and the burst main
//            memory (slave).
// Ports    : request side  mem_valid_i, mem_ready_o, mem_we_i, mem_addr_i,
//                          mem_wdata_i
//            response side mem_valid_o, mem_ready_i, mem_data_o, mem_last_o,
//                          mem_wdone_o
//            Signal suffixes are seen from the memory: _i enters the memory.
// Revision : 1.0 - initial release
// ============================================================================
interface main_memory_burst_if #(
    parameter int DMA_DATA_WIDTH_P = 2
);
    logic                          mem_valid_i;
    logic                          mem_ready_o;
    logic                          mem_we_i;
    logic [31:0]                   mem_addr_i;
    logic [DMA_DATA_WIDTH_P*32-1:0] mem_wdata_i;
    logic                          mem_valid_o;
    logic                          mem_ready_i;
    logic [DMA_DATA_WIDTH_P*32-1:0] mem_data_o;
    logic                          mem_last_o;
    logic                          mem_wdone_o;

    modport master (
        output mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_ready_i,
        input  mem_ready_o, mem_valid_o, mem_data_o, mem_last_o, mem_wdone_o
    );

    modport slave (
        input  mem_valid_i, mem_we_i, mem_addr_i, mem_wdata_i, mem_ready_i,
        output mem_ready_o, mem_valid_o, mem_data_o, mem_last_o, mem_wdone_o
    );
endinterface
`default_nettype wire

// File: rtl/main_memory_array.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_array
// Purpose  : Flat 32-bit word storage with one beat-wide write port and one
//            beat-wide asynchronous read port. Whole array clears on reset.
// Ports    : clk_i, reset_i          clock, synchronous active-high clear
//            wr_en, wr_addr, wr_data beat write, word address of word 0
//            rd_addr, rd_data        beat read, word address of word 0
// Revision : 1.0 - initial release
// ============================================================================
module main_memory_array
    import main_memory_pkg::*;
#(
    parameter int ELS_P            = 1024,
    parameter int DMA_DATA_WIDTH_P = 2,
    parameter int ADDR_WIDTH_P     = clog2_min1(ELS_P)
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          wr_en,
    input  logic [ADDR_WIDTH_P-1:0]       wr_addr,
    input  logic [DMA_DATA_WIDTH_P*32-1:0] wr_data,
    input  logic [ADDR_WIDTH_P-1:0]       rd_addr,
    output logic [DMA_DATA_WIDTH_P*32-1:0] rd_data
);

    logic [31:0] r_mem [ELS_P];

    // Beat addresses are always beat-aligned inside a block, so adding the
    // word index never carries past the block.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int i = 0; i < ELS_P; i++) begin
                r_mem[i] <= '0;
            end
        end else if (wr_en) begin
            for (int w = 0; w < DMA_DATA_WIDTH_P; w++) begin
                r_mem[wr_addr + ADDR_WIDTH_P'(w)] <= wr_data[32*w +: 32];
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int w = 0; w < DMA_DATA_WIDTH_P; w++) begin
            rd_data[32*w +: 32] = r_mem[rd_addr + ADDR_WIDTH_P'(w)];
        end
    end

endmodule
`default_nettype wire

// File: rtl/main_memory_burst.sv
`default_nettype none
// ============================================================================
// Module   : main_memory_burst
// Purpose  : Cycle-approximate main-memory model. Moves whole cache blocks as
//            multi-beat bursts with programmable access latency, read-side
//            backpressure, write-done pulse and optional critical-word-first
//            read ordering.
// Ports    : clk_i    clock, rising edge
//            reset_i  synchronous active-high reset
//            bus      main_memory_burst_if.slave (request/write beats in,
//                     read beats, last and write-done out)
// Revision : 1.0 - initial release
// ============================================================================
module main_memory_burst
    import main_memory_pkg::*;
#(
    parameter int ELS_P             = 1024,
    parameter int DMA_DATA_WIDTH_P  = 2,
    parameter int BLOCK_WIDTH_P     = 8,
    parameter int LATENCY_P         = 4,
    parameter int CRIT_WORD_FIRST_P = 0
) (
    input  logic               clk_i,
    input  logic               reset_i,
    main_memory_burst_if.slave bus
);

    localparam int c_BEATS  = mem_beats(BLOCK_WIDTH_P, DMA_DATA_WIDTH_P);
    localparam int c_AW     = clog2_min1(ELS_P);
    localparam int c_BIW    = clog2_min1(c_BEATS);
    localparam int c_CW     = lat_cnt_width(LATENCY_P);
    localparam int c_DMA_SH = $clog2(DMA_DATA_WIDTH_P);
    localparam int c_RD_WAIT_LAST = (LATENCY_P >= 2) ? LATENCY_P - 2 : 0;

    localparam logic [c_AW-1:0]  c_BLK_MASK  = c_AW'(BLOCK_WIDTH_P - 1);
    localparam logic [c_BIW-1:0] c_LAST_BEAT = c_BIW'(c_BEATS - 1);
    localparam logic [c_CW-1:0]  c_LAT_LAST  = c_CW'(LATENCY_P - 1);
    localparam logic [c_CW-1:0]  c_RD_LAST   = c_CW'(c_RD_WAIT_LAST);

    localparam logic [2:0] c_ST_IDLE     = MEM_IDLE;
    localparam logic [2:0] c_ST_RD_WAIT  = MEM_RD_WAIT;
    localparam logic [2:0] c_ST_RD_BURST = MEM_RD_BURST;
    localparam logic [2:0] c_ST_WR_BURST = MEM_WR_BURST;
    localparam logic [2:0] c_ST_WR_WAIT  = MEM_WR_WAIT;

    logic [2:0]       r_state;
    logic [c_CW-1:0]  r_lat_cnt;
    logic [c_BIW-1:0] r_beat_idx;   // beat position within the block
    logic [c_BIW-1:0] r_beat_cnt;   // read beats already handed over
    logic [c_AW-1:0]  r_base;

    logic [c_AW-1:0]  w_word_addr;
    logic [c_AW-1:0]  w_req_base;
    logic [c_AW-1:0]  w_offset;
    logic [c_BIW-1:0] w_req_start;
    logic [c_BIW-1:0] w_next_idx;
    logic [c_AW-1:0]  w_beat_addr;
    logic             w_ready;
    logic             w_rd_valid;
    logic             w_wr_en;
    logic [c_AW-1:0]  w_wr_addr;
    logic [DMA_DATA_WIDTH_P*32-1:0] w_rd_data;
    logic             w_unused_addr;

    // Taking only the low word-address bits gives the wrap-around aliasing
    // for free; byte-lane bits and the upper address are deliberately dropped.
    assign w_word_addr   = bus.mem_addr_i[2 +: c_AW];
    assign w_unused_addr = ^bus.mem_addr_i;
    assign w_req_base    = w_word_addr & ~c_BLK_MASK;

    always_comb begin
        w_offset    = w_word_addr & c_BLK_MASK;
        w_req_start = '0;
        if (CRIT_WORD_FIRST_P != 0) begin
            w_req_start = c_BIW'(w_offset >> c_DMA_SH);
        end
    end

    // Beat index wraps inside the block so critical-word-first reads cover
    // every beat exactly once.
    assign w_next_idx  = (r_beat_idx == c_LAST_BEAT) ? '0 : r_beat_idx + c_BIW'(1);
    assign w_beat_addr = r_base + (c_AW'(r_beat_idx) << c_DMA_SH);

    // Ready depends only on state (and reset), never on mem_valid_i.
    assign w_ready    = ~reset_i & ((r_state == c_ST_IDLE) | (r_state == c_ST_WR_BURST));
    assign w_rd_valid = (r_state == c_ST_RD_BURST);

    // Beat 0 of a write lands on the request handshake itself, so the
    // write address is taken from the bus while idle.
    assign w_wr_en   = bus.mem_valid_i & w_ready &
                       (((r_state == c_ST_IDLE) & bus.mem_we_i) | (r_state == c_ST_WR_BURST));
    assign w_wr_addr = (r_state == c_ST_IDLE) ? w_req_base : w_beat_addr;

    main_memory_array #(
        .ELS_P            (ELS_P),
        .DMA_DATA_WIDTH_P (DMA_DATA_WIDTH_P),
        .ADDR_WIDTH_P     (c_AW)
    ) u_array (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .wr_en   (w_wr_en),
        .wr_addr (w_wr_addr),
        .wr_data (bus.mem_wdata_i),
        .rd_addr (w_beat_addr),
        .rd_data (w_rd_data)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state    <= c_ST_IDLE;
            r_lat_cnt  <= '0;
            r_beat_idx <= '0;
            r_beat_cnt <= '0;
            r_base     <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.mem_valid_i) begin
                        r_base     <= w_req_base;
                        r_lat_cnt  <= '0;
                        r_beat_cnt <= '0;
                        if (bus.mem_we_i) begin
                            // Beat 0 is written now; next write goes to beat 1.
                            r_beat_idx <= (c_BEATS == 1) ? '0 : c_BIW'(1);
                            r_state    <= (c_BEATS == 1) ? c_ST_WR_WAIT : c_ST_WR_BURST;
                        end else begin
                            r_beat_idx <= w_req_start;
                            r_state    <= (LATENCY_P == 1) ? c_ST_RD_BURST : c_ST_RD_WAIT;
                        end
                    end
                end
                c_ST_RD_WAIT: begin
                    // Handshake cycle plus latency-1 wait cycles puts the
                    // first beat exactly latency cycles after the request.
                    if (r_lat_cnt == c_RD_LAST) begin
                        r_state <= c_ST_RD_BURST;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_CW'(1);
                    end
                end
                c_ST_RD_BURST: begin
                    if (bus.mem_ready_i) begin
                        r_beat_idx <= w_next_idx;
                        r_beat_cnt <= r_beat_cnt + c_BIW'(1);
                        if (r_beat_cnt == c_LAST_BEAT) begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                c_ST_WR_BURST: begin
                    if (bus.mem_valid_i) begin
                        r_beat_idx <= w_next_idx;
                        if (r_beat_idx == c_LAST_BEAT) begin
                            r_lat_cnt <= '0;
                            r_state   <= c_ST_WR_WAIT;
                        end
                    end
                end
                c_ST_WR_WAIT: begin
                    if (r_lat_cnt == c_LAT_LAST) begin
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt + c_CW'(1);
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_ready_o = w_ready;
    assign bus.mem_valid_o = w_rd_valid;
    assign bus.mem_data_o  = w_rd_valid ? w_rd_data : '0;
    assign bus.mem_last_o  = w_rd_valid & (r_beat_cnt == c_LAST_BEAT);
    assign bus.mem_wdone_o = (r_state == c_ST_WR_WAIT) & (r_lat_cnt == c_LAT_LAST);

endmodule
`default_nettype wire

// File: tb/tb_main_memory_burst.sv
`default_nettype none
// ============================================================================
// Module   : tb_main_memory_burst
// Purpose  : Self-checking bench for main_memory_burst. Two instances share
//            the same stimulus: dut0 with ascending reads, dut1 with
//            critical-word-first reads. A word-level memory model predicts
//            every read beat into a per-instance queue; beats are popped and
//            compared as the instances hand them over. Cycle-exact ready,
//            valid, last and wdone timing is checked on dut0.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_main_memory_burst;

    localparam int c_LAT   = 4;
    localparam int c_BEATS = 4;
    localparam int c_DMA   = 2;
    localparam int c_BLOCK = 8;
    localparam int c_ELS   = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    main_memory_burst_if #(.DMA_DATA_WIDTH_P(c_DMA)) b0 ();
    main_memory_burst_if #(.DMA_DATA_WIDTH_P(c_DMA)) b1 ();

    assign b1.mem_valid_i = b0.mem_valid_i;
    assign b1.mem_we_i    = b0.mem_we_i;
    assign b1.mem_addr_i  = b0.mem_addr_i;
    assign b1.mem_wdata_i = b0.mem_wdata_i;
    assign b1.mem_ready_i = b0.mem_ready_i;

    main_memory_burst #(
        .ELS_P(c_ELS), .DMA_DATA_WIDTH_P(c_DMA), .BLOCK_WIDTH_P(c_BLOCK),
        .LATENCY_P(c_LAT), .CRIT_WORD_FIRST_P(0)
    ) dut0 (.clk_i(clk), .reset_i(rst), .bus(b0));

    main_memory_burst #(
        .ELS_P(c_ELS), .DMA_DATA_WIDTH_P(c_DMA), .BLOCK_WIDTH_P(c_BLOCK),
        .LATENCY_P(c_LAT), .CRIT_WORD_FIRST_P(1)
    ) dut1 (.clk_i(clk), .reset_i(rst), .bus(b1));

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] model [c_ELS];
    logic [64:0] q0 [$];
    logic [64:0] q1 [$];
    logic [64:0] exp0;
    logic [64:0] exp1;

    task automatic check_eq(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int word_of(input logic [31:0] addr);
        return int'(addr[31:2]) % c_ELS;
    endfunction

    // Predict all four beats of a read for both orderings.
    task automatic push_read(input logic [31:0] addr);
        int w, base, start1, i0, i1;
        w      = word_of(addr);
        base   = w & ~(c_BLOCK - 1);
        start1 = (w % c_BLOCK) / c_DMA;
        for (int k = 0; k < c_BEATS; k++) begin
            i0 = base + k * c_DMA;
            i1 = base + ((start1 + k) % c_BEATS) * c_DMA;
            q0.push_back({(k == c_BEATS - 1), model[i0 + 1], model[i0]});
            q1.push_back({(k == c_BEATS - 1), model[i1 + 1], model[i1]});
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && b0.mem_valid_o === 1'b1 && b0.mem_ready_i === 1'b1) begin
            if (q0.size() == 0) begin
                check_eq("rd0_unexpected_beat", 96'(b0.mem_valid_o), 96'd0);
            end else begin
                exp0 = q0.pop_front();
                check_eq("rd0_beat", 96'({b0.mem_last_o, b0.mem_data_o}), 96'(exp0));
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && b1.mem_valid_o === 1'b1 && b1.mem_ready_i === 1'b1) begin
            if (q1.size() == 0) begin
                check_eq("rd1_unexpected_beat", 96'(b1.mem_valid_o), 96'd0);
            end else begin
                exp1 = q1.pop_front();
                check_eq("rd1_cwf_beat", 96'({b1.mem_last_o, b1.mem_data_o}), 96'(exp1));
            end
        end
    end

    // Write burst with the request in cycle 0 and beats in cycles 0-3;
    // address is garbage after cycle 0 because it must be ignored.
    task automatic write_block(input string nm, input logic [31:0] addr, input logic [255:0] blk);
        int base;
        base = word_of(addr) & ~(c_BLOCK - 1);
        for (int c = 0; c <= 8; c++) begin
            b0.mem_valid_i = (c < c_BEATS);
            b0.mem_we_i    = (c == 0);
            b0.mem_addr_i  = (c == 0) ? addr : 32'hFFFF_FFFC;
            b0.mem_wdata_i = (c < c_BEATS) ? blk[64*c +: 64] : 64'd0;
            if (c < c_BEATS) begin
                model[base + 2*c]     = blk[64*c +: 32];
                model[base + 2*c + 1] = blk[64*c + 32 +: 32];
            end
            @(negedge clk);
            check_eq({nm, "_ready"}, 96'(b0.mem_ready_o), 96'(c <= 3 || c == 8));
            check_eq({nm, "_wdone"}, 96'(b0.mem_wdone_o), 96'(c == 7));
            @(posedge clk); #1;
        end
    endtask

    // Read with the request in cycle 0; mem_ready_i low in cycles
    // stall_lo..stall_hi (none when stall_lo > stall_hi). With inject set, a
    // write request to 0x80 is attempted in cycle 2 while the memory is busy.
    task automatic read_block(input string nm, input logic [31:0] addr,
                              input int stall_lo, input int stall_hi, input bit inject);
        int          nst, base;
        logic [63:0] hold;
        nst  = (stall_hi >= stall_lo) ? (stall_hi - stall_lo + 1) : 0;
        base = word_of(addr) & ~(c_BLOCK - 1);
        hold = 64'd0;
        if (nst > 0) begin
            hold = {model[base + 2*(stall_lo - 4) + 1], model[base + 2*(stall_lo - 4)]};
        end
        push_read(addr);
        for (int c = 0; c <= 8 + nst; c++) begin
            b0.mem_valid_i = (c == 0) || (inject && c == 2);
            b0.mem_we_i    = inject && (c == 2);
            b0.mem_addr_i  = (c == 0) ? addr : 32'h0000_0080;
            b0.mem_wdata_i = (inject && c == 2) ? 64'hDEAD_BEEF_CAFE_F00D : 64'd0;
            b0.mem_ready_i = !(nst > 0 && c >= stall_lo && c <= stall_hi);
            @(negedge clk);
            check_eq({nm, "_valid"}, 96'(b0.mem_valid_o), 96'(c >= 4 && c <= 7 + nst));
            check_eq({nm, "_last"},  96'(b0.mem_last_o),  96'(c == 7 + nst));
            check_eq({nm, "_ready"}, 96'(b0.mem_ready_o), 96'(c == 0 || c == 8 + nst));
            if (!(c >= 4 && c <= 7 + nst)) begin
                check_eq({nm, "_idle_data"}, 96'(b0.mem_data_o), 96'd0);
            end
            if (nst > 0 && c >= stall_lo && c <= stall_hi + 1) begin
                check_eq({nm, "_hold_data"}, 96'(b0.mem_data_o), 96'(hold));
            end
            @(posedge clk); #1;
        end
        b0.mem_ready_i = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < c_ELS; i++) model[i] = 32'd0;
        rst            = 1'b1;
        b0.mem_valid_i = 1'b0;
        b0.mem_we_i    = 1'b0;
        b0.mem_addr_i  = 32'd0;
        b0.mem_wdata_i = 64'd0;
        b0.mem_ready_i = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rst_ready", 96'(b0.mem_ready_o), 96'd0);
        check_eq("rst_valid", 96'(b0.mem_valid_o), 96'd0);
        check_eq("rst_last",  96'(b0.mem_last_o),  96'd0);
        check_eq("rst_wdone", 96'(b0.mem_wdone_o), 96'd0);
        check_eq("rst_data",  96'(b0.mem_data_o),  96'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 96'(b0.mem_ready_o), 96'd1);
        @(posedge clk); #1;

        write_block("wr", 32'h0000_0040,
                    {32'd8, 32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1});
        read_block("rd",  32'h0000_004C, 1, 0, 1'b0);
        read_block("bp",  32'h0000_004C, 5, 6, 1'b0);
        read_block("cwf", 32'h0000_0054, 1, 0, 1'b0);

        // Reset in cycle 5 of a read: no further beats, storage cleared.
        push_read(32'h0000_0040);
        for (int c = 0; c <= 10; c++) begin
            rst            = (c == 5);
            b0.mem_valid_i = (c == 0);
            b0.mem_we_i    = 1'b0;
            b0.mem_addr_i  = 32'h0000_0040;
            b0.mem_ready_i = 1'b1;
            @(negedge clk);
            if (c == 5) check_eq("mid_rst_ready", 96'(b0.mem_ready_o), 96'd0);
            if (c == 6) check_eq("mid_rst_ready_after", 96'(b0.mem_ready_o), 96'd1);
            if (c >= 6) begin
                check_eq("mid_rst_valid0", 96'(b0.mem_valid_o), 96'd0);
                check_eq("mid_rst_last0",  96'(b0.mem_last_o),  96'd0);
                check_eq("mid_rst_valid1", 96'(b1.mem_valid_o), 96'd0);
            end
            @(posedge clk); #1;
            if (c == 5) begin
                q0.delete();
                q1.delete();
                for (int i = 0; i < c_ELS; i++) model[i] = 32'd0;
            end
        end
        read_block("rz", 32'h0000_0040, 1, 0, 1'b0);

        write_block("ww", 32'h0000_1000, {8{32'd9}});
        read_block("wrap", 32'h0000_0000, 1, 0, 1'b1);
        read_block("ign",  32'h0000_0080, 1, 0, 1'b0);

        check_eq("q0_drained", 96'(q0.size()), 96'd0);
        check_eq("q1_drained", 96'(q1.size()), 96'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
